wb_downsizer: RTL and testbench
===============================

// Module: wb_downsizer
// PURPOSE
//  Wishbone width converter, wide slave port -> narrow master port (inverse of the interconnect upsizer).
//  Each wide access is split into up to SCALE narrow beats, one per byte-lane group with nonzero sel.
//  Read beats are gathered into one wide word; one wide ack/err/rty per access.
//  Sits between a wide-bus master and narrow wb_intercon slaves.
// PARAMETERS
//  DW_OUT  32  narrow (master-side) data width, multiple of 8
//  SCALE   2   width ratio; slave width DW_IN = DW_OUT*SCALE; power of 2, >=2
//  AW      32  address width, both ports
// PORTS
//  wb_clk_i   in   1             clock
//  wb_rst_ni  in   1             reset, asynchronous, active-low
//  wbs_adr_i  in   AW            wide byte address
//  wbs_dat_i  in   DW_IN         write data
//  wbs_sel_i  in   DW_IN/8       byte selects
//  wbs_we_i   in   1             write enable
//  wbs_cyc_i  in   1             cycle
//  wbs_stb_i  in   1             strobe
//  wbs_cti_i  in   3             ignored; every access treated as classic
//  wbs_bte_i  in   2             ignored
//  wbs_dat_o  out  DW_IN         read data, valid with wbs_ack_o
//  wbs_ack_o  out  1             access done
//  wbs_err_o  out  1             access failed
//  wbs_rty_o  out  1             retry requested
//  wbm_adr_o  out  AW            narrow byte address
//  wbm_dat_o  out  DW_OUT        write data for current lane
//  wbm_sel_o  out  DW_OUT/8      byte selects for current lane
//  wbm_we_o / wbm_cyc_o / wbm_stb_o  out  1  master controls
//  wbm_cti_o  out  3             010 mid-burst, 111 last beat
//  wbm_bte_o  out  2             always 00 (linear)
//  wbm_dat_i  in   DW_OUT        read data
//  wbm_ack_i / wbm_err_i / wbm_rty_i  in  1  narrow terminations
// BEHAVIOUR
//  - Reset (wb_rst_ni=0, async): state IDLE; all outputs 0; data/sel/lane regs cleared.
//  - Lane k = wide bits [k*DW_OUT +: DW_OUT], sel [k*DW_OUT/8 +: DW_OUT/8]; lane 0 = lowest address.
//  - Lane active iff its sel slice != 0; beats issued in ascending k, inactive lanes skipped.
//  - States IDLE, XFER, RESP.
//  - IDLE: on cyc&stb latch aligned base adr (low log2(DW_IN/8) bits zeroed), dat, sel, we.
//    Any lane active -> XFER, first active lane. sel==0 -> RESP with ack, no master access.
//  - XFER: cyc=stb=1, we=latched we, adr=base+k*(DW_OUT/8), dat/sel=lane k.
//    cti=111 if k is last active lane, else 010.
//  - ack_i: read -> store dat_i into lane k of rdat; advance to next active lane in the next cycle
//    (no idle cycle); after last lane -> RESP(ack).
//  - err_i / rty_i on any beat -> drop master cyc next cycle, RESP(err / rty); remaining lanes not issued.
//  - RESP: exactly one cycle of wbs_ack_o | wbs_err_o | wbs_rty_o (mutually exclusive), then IDLE.
//    wbs_dat_o = rdat (unread lanes 0, cleared at each new access).
//  - Terminations are registered; wbs_* never combinationally depends on wbm_*_i.
//  - Latency: N active lanes, zero-wait slave -> wbs_ack_o in cycle N+2 after stb sampled in IDLE.
//  - wbs_cyc_i low during XFER: wbm_cyc_o/stb_o drop same cycle (combinationally gated); back to IDLE,
//    no slave termination; any wbm_ack_i in that cycle is ignored.
//  - Simultaneous ack_i and err_i: err wins.
//  - New request held during RESP is not sampled until IDLE (one cycle gap minimum between accesses).
// TESTING
//  - SCALE=2, read adr 0x100 sel 0xFF, slave returns 0x11111111 then 0x22222222 ->
//    wbm_adr 0x100 (cti 010), 0x104 (cti 111); wbs_dat_o 0x22222222_11111111 with ack.
//  - Write adr 0x208 sel 0xF0 dat 0xAABBCCDD_00000000 -> one beat adr 0x20C, sel 0xF, dat 0xAABBCCDD, cti 111.
//  - Write sel 0x00 -> wbs_ack_o after 2 cycles, wbm_cyc_o never asserted.
//  - Read, err_i on beat 0 -> beat 1 never issued, wbs_err_o one cycle, no ack.
//  - wbs_cyc_i dropped with beat 1 outstanding -> wbm_cyc_o low same cycle, no wbs_ack_o, next access OK.
//  - Assert wb_rst_ni low mid-XFER -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/wb_downsizer.sv
// wb_downsizer: splits each wide Wishbone access into one narrow beat per
// byte-lane group with a nonzero select, gathers read beats into one wide word
// and returns a single registered termination per wide access.
//
// state | meaning
// IDLE  | waiting for a wide request
// XFER  | issuing narrow beats, one active lane at a time
// RESP  | one-cycle wide ack/err/rty
module wb_downsizer #(
  parameter  int DW_OUT = 32,
  parameter  int SCALE  = 2,
  parameter  int AW     = 32,
  localparam int DW_IN  = DW_OUT * SCALE,
  localparam int SW_OUT = DW_OUT / 8,
  localparam int SW_IN  = DW_IN / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [AW-1:0]     wbs_adr_i,
  input  logic [DW_IN-1:0]  wbs_dat_i,
  input  logic [SW_IN-1:0]  wbs_sel_i,
  input  logic              wbs_we_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic [2:0]        wbs_cti_i,
  input  logic [1:0]        wbs_bte_i,
  output logic [DW_IN-1:0]  wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic              wbs_rty_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW_OUT-1:0] wbm_dat_o,
  output logic [SW_OUT-1:0] wbm_sel_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic [2:0]        wbm_cti_o,
  output logic [1:0]        wbm_bte_o,
  input  logic [DW_OUT-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i
);

  localparam int LW   = $clog2(SCALE);
  localparam int OFFS = $clog2(SW_IN);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t            state;
  logic [AW-1:0]     base_q;
  logic [DW_IN-1:0]  wdat_q;
  logic [DW_IN-1:0]  rdat_q;
  logic [SW_IN-1:0]  sel_q;
  logic [LW-1:0]     lane_q;
  logic              cyc_q;

  logic [AW-1:0]     src_base;
  logic [DW_IN-1:0]  src_dat;
  logic [SW_IN-1:0]  src_sel;
  logic [LW:0]       src_from;
  logic [LW:0]       nxt;
  logic [LW:0]       aft;
  logic              nxt_found;
  logic [LW-1:0]     nxt_idx;
  logic              nxt_last;
  logic [AW-1:0]     beat_adr;
  logic [DW_OUT-1:0] beat_dat;
  logic [SW_OUT-1:0] beat_sel;
  logic              unused_ok;

  // Lowest active lane at or above 'from'; MSB of the result flags a hit.
  function automatic logic [LW:0] find_lane(input logic [SW_IN-1:0] s, input logic [LW:0] from);
    logic [LW:0] r;
    r = '0;
    for (int i = SCALE - 1; i >= 0; i--)
      if (i >= int'(from) && |s[i*SW_OUT +: SW_OUT]) r = {1'b1, LW'(i)};
    return r;
  endfunction

  // Next beat: first active lane of a fresh request, or the one after the current lane.
  always_comb begin
    if (state == IDLE) begin
      src_base = {wbs_adr_i[AW-1:OFFS], {OFFS{1'b0}}};
      src_dat  = wbs_dat_i;
      src_sel  = wbs_sel_i;
      src_from = '0;
    end else begin
      src_base = base_q;
      src_dat  = wdat_q;
      src_sel  = sel_q;
      src_from = {1'b0, lane_q} + (LW+1)'(1);
    end
    nxt       = find_lane(src_sel, src_from);
    nxt_found = nxt[LW];
    nxt_idx   = nxt[LW-1:0];
    aft       = find_lane(src_sel, {1'b0, nxt_idx} + (LW+1)'(1));
    nxt_last  = ~aft[LW];
    beat_adr  = src_base + AW'(nxt_idx) * AW'(SW_OUT);
    beat_dat  = '0;
    beat_sel  = '0;
    for (int i = 0; i < SCALE; i++) begin
      if (nxt_idx == LW'(i)) begin
        beat_dat = src_dat[i*DW_OUT +: DW_OUT];
        beat_sel = src_sel[i*SW_OUT +: SW_OUT];
      end
    end
  end

  // Sequencer: latches the request, walks active lanes, registers the wide termination.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      base_q    <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      sel_q     <= '0;
      lane_q    <= '0;
      cyc_q     <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_cti_o <= 3'b000;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_rty_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            base_q   <= src_base;
            wdat_q   <= wbs_dat_i;
            sel_q    <= wbs_sel_i;
            wbm_we_o <= wbs_we_i;
            rdat_q   <= '0;
            if (nxt_found) begin
              state     <= XFER;
              cyc_q     <= 1'b1;
              lane_q    <= nxt_idx;
              wbm_adr_o <= beat_adr;
              wbm_dat_o <= beat_dat;
              wbm_sel_o <= beat_sel;
              wbm_cti_o <= nxt_last ? 3'b111 : 3'b010;
            end else begin
              state     <= RESP;
              wbs_ack_o <= 1'b1;
            end
          end
        end
        XFER: begin
          if (!wbs_cyc_i) begin
            // Master abandoned the access: no wide termination, late narrow acks ignored.
            state     <= IDLE;
            cyc_q     <= 1'b0;
            wbm_cti_o <= 3'b000;
          end else if (wbm_err_i) begin
            state     <= RESP;
            cyc_q     <= 1'b0;
            wbm_cti_o <= 3'b000;
            wbs_err_o <= 1'b1;
          end else if (wbm_rty_i) begin
            state     <= RESP;
            cyc_q     <= 1'b0;
            wbm_cti_o <= 3'b000;
            wbs_rty_o <= 1'b1;
          end else if (wbm_ack_i) begin
            if (!wbm_we_o) begin
              for (int i = 0; i < SCALE; i++)
                if (lane_q == LW'(i)) rdat_q[i*DW_OUT +: DW_OUT] <= wbm_dat_i;
            end
            if (nxt_found) begin
              lane_q    <= nxt_idx;
              wbm_adr_o <= beat_adr;
              wbm_dat_o <= beat_dat;
              wbm_sel_o <= beat_sel;
              wbm_cti_o <= nxt_last ? 3'b111 : 3'b010;
            end else begin
              state     <= RESP;
              cyc_q     <= 1'b0;
              wbm_cti_o <= 3'b000;
              wbs_ack_o <= 1'b1;
            end
          end
        end
        RESP: begin
          state     <= IDLE;
          wbs_ack_o <= 1'b0;
          wbs_err_o <= 1'b0;
          wbs_rty_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Master strobe is gated by the wide cycle so an abort takes effect the same cycle.
  assign wbm_cyc_o = cyc_q & wbs_cyc_i;
  assign wbm_stb_o = cyc_q & wbs_cyc_i;
  assign wbm_bte_o = 2'b00;
  assign wbs_dat_o = rdat_q;

  assign unused_ok = ^{wbs_cti_i, wbs_bte_i, wbs_adr_i[OFFS-1:0]};

endmodule

// File: tb/tb_wb_downsizer.sv
// Directed bench for wb_downsizer with SCALE=2, DW_OUT=32: narrow slave is
// driven by hand from the stimulus sequence, outputs sampled on the falling edge.
module tb_wb_downsizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wbs_adr_i = '0;
  logic [63:0] wbs_dat_i = '0;
  logic [7:0]  wbs_sel_i = '0;
  logic        wbs_we_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic [2:0]  wbs_cti_i = '0;
  logic [1:0]  wbs_bte_i = '0;
  logic [63:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        wbm_rty_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  wb_downsizer #(.DW_OUT(32), .SCALE(2), .AW(32)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] adr, input logic [63:0] dat, input logic [7:0] sel, input logic we);
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
  endtask

  task automatic drop();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic slave(input logic ack, input logic err, input logic rty, input logic [31:0] d);
    wbm_ack_i = ack; wbm_err_i = err; wbm_rty_i = rty; wbm_dat_i = d;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_cyc", 64'(wbm_cyc_o), 64'h0);
    chk("rst_ack", 64'(wbs_ack_o), 64'h0);
    chk("rst_adr", 64'(wbm_adr_o), 64'h0);
    chk("rst_dat", wbs_dat_o, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // two-lane read
    @(negedge clk); req(32'h100, 64'h0, 8'hFF, 1'b0);
    @(negedge clk);
    chk("rd_b0_cyc", 64'({wbm_cyc_o, wbm_stb_o}), 64'h3);
    chk("rd_b0_adr", 64'(wbm_adr_o), 64'h100);
    chk("rd_b0_cti", 64'(wbm_cti_o), 64'h2);
    chk("rd_b0_sel", 64'(wbm_sel_o), 64'hF);
    chk("rd_b0_we",  64'(wbm_we_o), 64'h0);
    slave(1'b1, 1'b0, 1'b0, 32'h11111111);
    @(negedge clk);
    chk("rd_b1_adr", 64'(wbm_adr_o), 64'h104);
    chk("rd_b1_cti", 64'(wbm_cti_o), 64'h7);
    chk("rd_b1_ack_early", 64'(wbs_ack_o), 64'h0);
    slave(1'b1, 1'b0, 1'b0, 32'h22222222);
    @(negedge clk);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rd_ack", 64'(wbs_ack_o), 64'h1);
    chk("rd_dat", wbs_dat_o, 64'h22222222_11111111);
    chk("rd_mcyc_off", 64'(wbm_cyc_o), 64'h0);
    chk("bte", 64'(wbm_bte_o), 64'h0);
    drop();
    @(negedge clk);
    chk("rd_ack_one", 64'(wbs_ack_o), 64'h0);

    // single upper-lane write
    req(32'h208, 64'hAABBCCDD_00000000, 8'hF0, 1'b1);
    @(negedge clk);
    chk("wr_adr", 64'(wbm_adr_o), 64'h20C);
    chk("wr_sel", 64'(wbm_sel_o), 64'hF);
    chk("wr_dat", 64'(wbm_dat_o), 64'hAABBCCDD);
    chk("wr_cti", 64'(wbm_cti_o), 64'h7);
    chk("wr_we",  64'(wbm_we_o), 64'h1);
    slave(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wr_ack", 64'(wbs_ack_o), 64'h1);
    chk("wr_mcyc_off", 64'(wbm_cyc_o), 64'h0);
    drop();
    @(negedge clk);

    // empty select: ack without any master access
    req(32'h300, 64'h0, 8'h00, 1'b1);
    @(negedge clk);
    chk("sel0_ack", 64'(wbs_ack_o), 64'h1);
    chk("sel0_mcyc", 64'(wbm_cyc_o), 64'h0);
    drop();
    @(negedge clk);
    chk("sel0_ack_one", 64'(wbs_ack_o), 64'h0);

    // err on beat 0 ends the access
    req(32'h400, 64'h0, 8'hFF, 1'b0);
    @(negedge clk);
    chk("err_b0_adr", 64'(wbm_adr_o), 64'h400);
    slave(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    chk("err_flag", 64'({wbs_ack_o, wbs_err_o, wbs_rty_o}), 64'h2);
    chk("err_mcyc_off", 64'(wbm_cyc_o), 64'h0);
    drop();
    @(negedge clk);
    chk("err_one", 64'(wbs_err_o), 64'h0);
    chk("err_no_b1", 64'(wbm_cyc_o), 64'h0);

    // ack and err together: err wins
    req(32'h600, 64'h0, 8'h0F, 1'b0);
    @(negedge clk);
    chk("ae_cti", 64'(wbm_cti_o), 64'h7);
    slave(1'b1, 1'b1, 1'b0, 32'h55555555);
    @(negedge clk);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ae_flag", 64'({wbs_ack_o, wbs_err_o, wbs_rty_o}), 64'h2);
    drop();
    @(negedge clk);

    // retry on beat 0
    req(32'h700, 64'h0, 8'hFF, 1'b1);
    @(negedge clk);
    slave(1'b0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rty_flag", 64'({wbs_ack_o, wbs_err_o, wbs_rty_o}), 64'h1);
    drop();
    @(negedge clk);

    // abort with beat 1 outstanding
    req(32'h300, 64'h0, 8'hFF, 1'b0);
    @(negedge clk);
    slave(1'b1, 1'b0, 1'b0, 32'h12121212);
    @(negedge clk);
    chk("ab_b1_adr", 64'(wbm_adr_o), 64'h304);
    drop();
    slave(1'b1, 1'b0, 1'b0, 32'h34343434);
    #1;
    chk("ab_mcyc_gate", 64'({wbm_cyc_o, wbm_stb_o}), 64'h0);
    @(negedge clk);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ab_no_ack", 64'({wbs_ack_o, wbs_err_o, wbs_rty_o}), 64'h0);
    req(32'h400, 64'hFFFFFFFF_12345678, 8'h0F, 1'b1);
    @(negedge clk);
    chk("ab_next_adr", 64'(wbm_adr_o), 64'h400);
    chk("ab_next_dat", 64'(wbm_dat_o), 64'h12345678);
    chk("ab_next_cti", 64'(wbm_cti_o), 64'h7);
    slave(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ab_next_ack", 64'(wbs_ack_o), 64'h1);
    chk("ab_next_rdat_clr", wbs_dat_o, 64'h0);
    drop();
    @(negedge clk);

    // async reset mid-transfer
    req(32'h500, 64'h0, 8'hFF, 1'b0);
    @(negedge clk);
    chk("rs_cyc_pre", 64'(wbm_cyc_o), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rs_cyc", 64'({wbm_cyc_o, wbm_stb_o}), 64'h0);
    chk("rs_adr", 64'(wbm_adr_o), 64'h0);
    chk("rs_cti", 64'(wbm_cti_o), 64'h0);
    drop();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_idle", 64'(wbm_cyc_o), 64'h0);

    // upper-lane read: unread lane stays zero
    req(32'h500, 64'h0, 8'hF0, 1'b0);
    @(negedge clk);
    chk("up_adr", 64'(wbm_adr_o), 64'h504);
    slave(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    chk("up_ack", 64'(wbs_ack_o), 64'h1);
    chk("up_dat", wbs_dat_o, 64'hDEADBEEF_00000000);
    drop();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
